des_key_schedule: RTL and testbench
===================================

DES_KEY_SCHEDULE -- requirements
Module: des_key_schedule

Interface
REQ-001 SHALL have port clk  input  1  single system clock; all state updates on rising edge.
REQ-002 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port keyValid  input  1  pc1Key is valid this cycle.
REQ-004 SHALL have port keyReady  output  1  block accepts a new key this cycle.
REQ-005 SHALL have port pc1Key  input  56  PC-1-permuted key; bits [55:28]=C0, [27:0]=D0.
REQ-006 SHALL have port decrypt  input  1  subkey order select, sampled at key accept (present only with DES_DECRYPT_EN).
REQ-007 SHALL have port subkeyValid  output  1  subkey/roundIdx valid.
REQ-008 SHALL have port subkeyReady  input  1  consumer accepts subkey this cycle.
REQ-009 SHALL have port subkey  output  48  PC-2 output for the current round.
REQ-010 SHALL have port roundIdx  output  4  round number minus one (0 = K1 ... 15 = K16).
REQ-011 SHALL have port scheduleDone  output  1  one-cycle pulse after the final subkey handshake.

Function
REQ-012 SHALL implement FSM states IDLE and RUN; keyReady=1 only in IDLE.
REQ-013 In IDLE, keyValid&keyReady SHALL load C,D registers, clear the round counter and enter RUN on the same edge.
REQ-014 Encrypt load SHALL store C0,D0 each rotated left by SHIFT[0]=1, so K1 is presented the cycle after accept (latency 1).
REQ-015 Shift schedule SHALL be SHIFT[0..15] = 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
REQ-016 subkey SHALL be combinational PC-2 of the registered {C,D}; subkeyValid=1 throughout RUN.
REQ-017 On subkeyValid&subkeyReady with counter<15: counter increments; encrypt rotates C,D left by SHIFT[counter+1].
REQ-018 On the handshake with counter==15: FSM returns to IDLE, scheduleDone pulses for exactly one cycle on the next cycle, C,D hold.
REQ-019 Without subkeyReady, subkey, roundIdx and C,D SHALL hold stable (no key skipped or repeated).
REQ-020 keyValid in RUN SHALL be ignored; keyReady returns the cycle after the last handshake (one-cycle bubble between keys).
REQ-021 Rotations SHALL be 28-bit circular within C and D independently; counter wraps only through the IDLE reload.

Reset
REQ-022 rst_n low SHALL asynchronously force IDLE, C=D=0, counter=0, decrypt flag=0.
REQ-023 Reset values: keyReady=1, subkeyValid=0, subkey=0, roundIdx=0, scheduleDone=0.
REQ-024 Reset asserted mid-RUN SHALL abandon the schedule; no further subkeys until a new key is accepted.

Configuration
REQ-025 Macro DES_DECRYPT_EN SHALL gate the decrypt port and reverse-order logic.
REQ-026 With DES_DECRYPT_EN and decrypt=1 at accept: load C0,D0 unrotated, first subkey is K16, roundIdx=15-counter, after each handshake rotate right by SHIFT[15-counter].
REQ-027 Without DES_DECRYPT_EN: no decrypt port, encrypt order only, no right-rotate logic synthesized.

Structure
REQ-028 Package des_pkg SHALL hold SHIFT table, PC-2 index table, width constants (56/48/28), and the FSM state enum.
REQ-029 PC-2 SHALL be a separate combinational sub-module des_pc2 (56-bit in, 48-bit out, FIPS 46-3 bit order, bit 1 = MSB).

Verification
REQ-030 Key 133457799BBCDFF1 -> pc1Key=F0CCAAF556678F, subkeyReady=1 -> K1=1B02EFFC7072 (roundIdx 0) next cycle, K16=CB3D8B0E17F5 at roundIdx 15, scheduleDone pulse, 16 valid cycles total.
REQ-031 Same key, subkeyReady toggled 1-of-3 cycles -> identical 16-key sequence, outputs stable while stalled, 48 cycles total.
REQ-032 DES_DECRYPT_EN, decrypt=1, same key -> first subkey CB3D8B0E17F5 (roundIdx 15), last 1B02EFFC7072 (roundIdx 0).
REQ-033 Second key held on keyValid during RUN -> keyReady=0, key accepted only after scheduleDone; 2nd schedule matches golden model.
REQ-034 rst_n pulsed low at roundIdx 7 -> subkeyValid=0, subkey=0 immediately; fresh key then yields K1 from round 0.

Source files
------------

// File: rtl/des_pkg.sv
// Shared constants, tables and helpers for the DES key schedule.
// Right-rotate helper exists only when DES_DECRYPT_EN is defined.
package des_pkg;

  localparam int unsigned KEY_W    = 56;
  localparam int unsigned SUBKEY_W = 48;
  localparam int unsigned HALF_W   = 28;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Left-shift count applied to produce round i+1 from round i.
  localparam logic [1:0] SHIFT [0:15] = '{
    2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
  };

  // FIPS 46-3 PC-2 selection, 1-based, bit 1 is the MSB of {C,D}.
  localparam logic [5:0] PC2_IDX [0:47] = '{
    6'd14, 6'd17, 6'd11, 6'd24, 6'd1,  6'd5,
    6'd3,  6'd28, 6'd15, 6'd6,  6'd21, 6'd10,
    6'd23, 6'd19, 6'd12, 6'd4,  6'd26, 6'd8,
    6'd16, 6'd7,  6'd27, 6'd20, 6'd13, 6'd2,
    6'd41, 6'd52, 6'd31, 6'd37, 6'd47, 6'd55,
    6'd30, 6'd40, 6'd51, 6'd45, 6'd33, 6'd48,
    6'd44, 6'd49, 6'd39, 6'd56, 6'd34, 6'd53,
    6'd46, 6'd42, 6'd50, 6'd36, 6'd29, 6'd32
  };

  function automatic logic [HALF_W-1:0] rotl28(input logic [HALF_W-1:0] x,
                                               input logic [1:0] n);
    return (n == 2'd2) ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
  endfunction

`ifdef DES_DECRYPT_EN
  function automatic logic [HALF_W-1:0] rotr28(input logic [HALF_W-1:0] x,
                                               input logic [1:0] n);
    return (n == 2'd2) ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
  endfunction
`endif

endpackage

// File: rtl/des_pc2.sv
// Combinational PC-2 compression of the 56-bit {C,D} register into a subkey.
module des_pc2
  import des_pkg::*;
(
  input  logic [KEY_W-1:0]    cd,
  output logic [SUBKEY_W-1:0] subkey
);

  always_comb begin
    subkey = '0;
    for (int unsigned i = 0; i < SUBKEY_W; i++) begin
      subkey[SUBKEY_W-1-i] = cd[KEY_W-PC2_IDX[i]];
    end
  end

endmodule

// File: rtl/des_key_schedule.sv
// DES round-key generator: accepts a PC-1 key, streams K1..K16 with valid/ready.
// Define DES_DECRYPT_EN to add the decrypt port and K16..K1 ordering.
module des_key_schedule
  import des_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                keyValid,
  output logic                keyReady,
  input  logic [KEY_W-1:0]    pc1Key,
`ifdef DES_DECRYPT_EN
  input  logic                decrypt,
`endif
  output logic                subkeyValid,
  input  logic                subkeyReady,
  output logic [SUBKEY_W-1:0] subkey,
  output logic [3:0]          roundIdx,
  output logic                scheduleDone
);

  state_t            state_q, state_d;
  logic [HALF_W-1:0] c_q, c_d;
  logic [HALF_W-1:0] d_q, d_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              done_q, done_d;
`ifdef DES_DECRYPT_EN
  logic              dec_q, dec_d;
`endif

  always_comb begin
    state_d = state_q;
    c_d     = c_q;
    d_d     = d_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
`ifdef DES_DECRYPT_EN
    dec_d   = dec_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (keyValid) begin
          state_d = RUN;
          cnt_d   = '0;
          // Encrypt preloads the first rotation so K1 is ready next cycle.
          c_d     = rotl28(pc1Key[KEY_W-1:HALF_W], SHIFT[0]);
          d_d     = rotl28(pc1Key[HALF_W-1:0], SHIFT[0]);
`ifdef DES_DECRYPT_EN
          dec_d   = decrypt;
          // C16,D16 equal C0,D0 (28 total shifts), so decrypt loads as-is.
          if (decrypt) begin
            c_d = pc1Key[KEY_W-1:HALF_W];
            d_d = pc1Key[HALF_W-1:0];
          end
`endif
        end
      end
      RUN: begin
        if (subkeyReady) begin
          if (cnt_q == 4'd15) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + 4'd1;
            c_d   = rotl28(c_q, SHIFT[cnt_q+4'd1]);
            d_d   = rotl28(d_q, SHIFT[cnt_q+4'd1]);
`ifdef DES_DECRYPT_EN
            if (dec_q) begin
              c_d = rotr28(c_q, SHIFT[4'd15-cnt_q]);
              d_d = rotr28(d_q, SHIFT[4'd15-cnt_q]);
            end
`endif
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      c_q     <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
`ifdef DES_DECRYPT_EN
      dec_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      c_q     <= c_d;
      d_q     <= d_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
`ifdef DES_DECRYPT_EN
      dec_q   <= dec_d;
`endif
    end
  end

  always_comb begin
    keyReady     = (state_q == IDLE);
    subkeyValid  = (state_q == RUN);
    scheduleDone = done_q;
    roundIdx     = cnt_q;
`ifdef DES_DECRYPT_EN
    if (dec_q) roundIdx = 4'd15 - cnt_q;
`endif
  end

  des_pc2 u_pc2 (
    .cd     ({c_q, d_q}),
    .subkey (subkey)
  );

endmodule

// File: tb/tb_des_key_schedule.sv
// Self-checking bench for des_key_schedule against a cumulative-rotation model.
module tb_des_key_schedule;

  logic        clk;
  logic        rst_n;
  logic        keyValid;
  logic        keyReady;
  logic [55:0] pc1Key;
  logic        decrypt;
  logic        subkeyValid;
  logic        subkeyReady;
  logic [47:0] subkey;
  logic [3:0]  roundIdx;
  logic        scheduleDone;

  int unsigned checks = 0;
  int unsigned fails  = 0;

  des_key_schedule dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .keyValid     (keyValid),
    .keyReady     (keyReady),
    .pc1Key       (pc1Key),
`ifdef DES_DECRYPT_EN
    .decrypt      (decrypt),
`endif
    .subkeyValid  (subkeyValid),
    .subkeyReady  (subkeyReady),
    .subkey       (subkey),
    .roundIdx     (roundIdx),
    .scheduleDone (scheduleDone)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam int unsigned SHIFT_REF [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};
  localparam int unsigned PC2_REF [48] = '{
    14,17,11,24,1,5, 3,28,15,6,21,10, 23,19,12,4,26,8, 16,7,27,20,13,2,
    41,52,31,37,47,55, 30,40,51,45,33,48, 44,49,39,56,34,53, 46,42,50,36,29,32};

  // Key K(round+1): rotate C0/D0 left by the cumulative shift count, then PC-2.
  function automatic logic [47:0] model_subkey(input logic [55:0] key, input int unsigned round);
    longint unsigned c, d, cr, dr;
    int unsigned s;
    logic [55:0] cd;
    logic [47:0] k;
    s = 0;
    for (int i = 0; i <= int'(round); i++) s += SHIFT_REF[i];
    s = s % 28;
    c  = 64'(key[55:28]);
    d  = 64'(key[27:0]);
    cr = ((c << s) | (c >> (28 - s))) & 64'h0FFF_FFFF;
    dr = ((d << s) | (d >> (28 - s))) & 64'h0FFF_FFFF;
    cd = {cr[27:0], dr[27:0]};
    k  = '0;
    for (int i = 0; i < 48; i++) k[47-i] = cd[56-PC2_REF[i]];
    return k;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [55:0] rand_key();
    logic [31:0] a, b;
    a = $urandom;
    b = $urandom;
    return {a[23:0], b};
  endfunction

  // Called at a negedge in IDLE; returns at the negedge where scheduleDone is high.
  // mode 0: always ready, 1: ready one cycle in three, 2: random ready.
  task automatic run_sched(input logic [55:0] key, input logic dec, input int unsigned mode,
                           input logic hold, input logic [55:0] next_key,
                           output logic [47:0] first, output logic [47:0] last,
                           output int unsigned cycles);
    int unsigned k, r, cyc;
    logic rdy;
    first = '0;
    last  = '0;
    chk("key_ready_idle", 64'(keyReady), 64'd1);
    keyValid = 1'b1;
    pc1Key   = key;
    decrypt  = dec;
    @(posedge clk);
    @(negedge clk);
    if (hold) begin
      pc1Key = next_key;
    end else begin
      keyValid = 1'b0;
    end
    k   = 0;
    cyc = 0;
    while (k < 16 && cyc < 200) begin
      r = dec ? 15 - k : k;
      chk("subkey_valid", 64'(subkeyValid), 64'd1);
      chk("key_ready_run", 64'(keyReady), 64'd0);
      chk("done_low_run", 64'(scheduleDone), 64'd0);
      chk("round_idx", 64'(roundIdx), 64'(r));
      chk("subkey", 64'(subkey), 64'(model_subkey(key, r)));
      if (k == 0) first = subkey;
      if (k == 15) last = subkey;
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = ((cyc % 3) == 2);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      subkeyReady = rdy;
      @(posedge clk);
      if (rdy) k++;
      cyc++;
      @(negedge clk);
    end
    subkeyReady = 1'b0;
    chk("all_keys_seen", 64'(k), 64'd16);
    chk("done_pulse", 64'(scheduleDone), 64'd1);
    chk("valid_low_done", 64'(subkeyValid), 64'd0);
    chk("key_ready_done", 64'(keyReady), 64'd1);
    cycles = cyc;
  endtask

  logic [47:0] first, last;
  int unsigned cycles, cyc;
  logic [55:0] key_a, key_b;
  logic        dec_r;

  initial begin
    rst_n       = 1'b0;
    keyValid    = 1'b0;
    pc1Key      = '0;
    decrypt     = 1'b0;
    subkeyReady = 1'b0;
    #7;
    chk("rst_key_ready", 64'(keyReady), 64'd1);
    chk("rst_valid", 64'(subkeyValid), 64'd0);
    chk("rst_subkey", 64'(subkey), 64'd0);
    chk("rst_round", 64'(roundIdx), 64'd0);
    chk("rst_done", 64'(scheduleDone), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Golden FIPS example, consumer always ready.
    run_sched(56'hF0CCAAF556678F, 1'b0, 0, 1'b0, '0, first, last, cycles);
    chk("golden_k1", 64'(first), 64'h1B02EFFC7072);
    chk("golden_k16", 64'(last), 64'hCB3D8B0E17F5);
    chk("golden_cycles", 64'(cycles), 64'd16);
    @(negedge clk);
    chk("done_one_cycle", 64'(scheduleDone), 64'd0);
    chk("key_ready_after", 64'(keyReady), 64'd1);

    // Same key, ready one cycle in three.
    run_sched(56'hF0CCAAF556678F, 1'b0, 1, 1'b0, '0, first, last, cycles);
    chk("stall_k1", 64'(first), 64'h1B02EFFC7072);
    chk("stall_k16", 64'(last), 64'hCB3D8B0E17F5);
    chk("stall_cycles", 64'(cycles), 64'd48);
    @(negedge clk);

`ifdef DES_DECRYPT_EN
    run_sched(56'hF0CCAAF556678F, 1'b1, 0, 1'b0, '0, first, last, cycles);
    chk("dec_first", 64'(first), 64'hCB3D8B0E17F5);
    chk("dec_last", 64'(last), 64'h1B02EFFC7072);
    chk("dec_cycles", 64'(cycles), 64'd16);
    @(negedge clk);
`endif

    // Second key held on keyValid for the whole first schedule.
    key_a = rand_key();
    key_b = rand_key();
    run_sched(key_a, 1'b0, 2, 1'b1, key_b, first, last, cycles);
    run_sched(key_b, 1'b0, 0, 1'b0, '0, first, last, cycles);
    chk("chain_k1", 64'(first), 64'(model_subkey(key_b, 0)));
    @(negedge clk);

    // Reset in the middle of a schedule.
    key_a       = rand_key();
    keyValid    = 1'b1;
    pc1Key      = key_a;
    decrypt     = 1'b0;
    @(posedge clk);
    @(negedge clk);
    keyValid    = 1'b0;
    subkeyReady = 1'b1;
    cyc = 0;
    while (roundIdx !== 4'd7 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk("reach_round7", 64'(roundIdx), 64'd7);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_valid", 64'(subkeyValid), 64'd0);
    chk("midrst_subkey", 64'(subkey), 64'd0);
    chk("midrst_round", 64'(roundIdx), 64'd0);
    chk("midrst_key_ready", 64'(keyReady), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("postrst_idle", 64'(subkeyValid), 64'd0);
    end
    subkeyReady = 1'b0;
    key_b = rand_key();
    run_sched(key_b, 1'b0, 0, 1'b0, '0, first, last, cycles);
    chk("postrst_k1", 64'(first), 64'(model_subkey(key_b, 0)));
    @(negedge clk);

    // Random keys with random back-pressure.
    for (int n = 0; n < 4; n++) begin
      key_a = rand_key();
`ifdef DES_DECRYPT_EN
      dec_r = 1'($urandom_range(0, 1));
`else
      dec_r = 1'b0;
`endif
      run_sched(key_a, dec_r, 2, 1'b0, '0, first, last, cycles);
      chk("rand_last", 64'(last), 64'(model_subkey(key_a, dec_r ? 0 : 15)));
      @(negedge clk);
    end

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
